// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: one frame (start, data LSB first, optional parity, stop)
// per accepted host write. Bit timing comes only from the sample_enable strobe.
module uart_tx_controller #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_enable,
    input  logic                 tx_en,
    input  logic                 tx_wr,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_overrun
);
    localparam int TW = $clog2(OVERSAMPLE);
    // DATA_BITS >= 5 keeps BW >= 3, wide enough to index the stop bits as well
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic                 parity_reg, parity_nxt;
    logic                 out_nxt, busy_nxt, done_nxt, ovr_nxt;
    logic                 bit_end;

    assign bit_end = sample_enable && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_out     <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            bit_cnt    <= bit_nxt;
            shift_reg  <= shift_nxt;
            parity_reg <= parity_nxt;
            tx_out     <= out_nxt;
            tx_busy    <= busy_nxt;
            tx_done    <= done_nxt;
            tx_overrun <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tick_nxt   = tick_cnt;
        bit_nxt    = bit_cnt;
        shift_nxt  = shift_reg;
        parity_nxt = parity_reg;
        out_nxt    = tx_out;
        busy_nxt   = tx_busy;
        done_nxt   = 1'b0;
        ovr_nxt    = tx_overrun | (tx_wr && state != IDLE);

        if (state != IDLE && sample_enable)
            tick_nxt = bit_end ? '0 : tick_cnt + 1'b1;

        unique case (state)
            IDLE: begin
                out_nxt = 1'b1;
                if (tx_wr && tx_en) begin
                    shift_nxt  = tx_data;
                    parity_nxt = ^tx_data ^ PARITY_ODD;
                    tick_nxt   = '0;
                    bit_nxt    = '0;
                    state_nxt  = START;
                    out_nxt    = 1'b0;
                    busy_nxt   = 1'b1;
                end
            end
            START: if (bit_end) begin
                state_nxt = DATA;
                bit_nxt   = '0;
                out_nxt   = shift_reg[0];
                shift_nxt = shift_reg >> 1;
            end
            DATA: if (bit_end) begin
                if (bit_cnt == DATA_LAST) begin
                    bit_nxt = '0;
                    if (PARITY_EN) begin
                        state_nxt = PARITY;
                        out_nxt   = parity_reg;
                    end else begin
                        state_nxt = STOP;
                        out_nxt   = 1'b1;
                    end
                end else begin
                    bit_nxt   = bit_cnt + 1'b1;
                    out_nxt   = shift_reg[0];
                    shift_nxt = shift_reg >> 1;
                end
            end
            PARITY: if (bit_end) begin
                state_nxt = STOP;
                bit_nxt   = '0;
                out_nxt   = 1'b1;
            end
            STOP: if (bit_end) begin
                if (bit_cnt == STOP_LAST) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    bit_nxt = bit_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Dropping the enable abandons the frame silently: no done pulse
        if (state != IDLE && !tx_en) begin
            state_nxt = IDLE;
            tick_nxt  = '0;
            bit_nxt   = '0;
            out_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end
    end
endmodule
